demux_fifo: RTL and testbench

//  1-to-2 steering block, the inverse of the team's 2:1 mux. One valid/ready input

---
 rtl/demux_fifo_if.sv | 43 ++++
 rtl/demux_fifo.sv | 117 +++++++++++
 tb/tb_demux_fifo.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/demux_fifo_if.sv
// Handshake bundle for demux_fifo: one producer stream in, two consumer streams out.
// Optional statistics signals exist only when DEMUX_FIFO_STATS_EN is defined.
interface demux_fifo_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             sel;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [LW-1:0]    a_level;
    logic [LW-1:0]    b_level;
`ifdef DEMUX_FIFO_STATS_EN
    logic [15:0]      a_count;
    logic [15:0]      b_count;
    logic             drop_sel_x;
`endif

    // master = producer plus both consumers; slave = the demux itself
    modport master (
        output in_data, in_valid, sel, a_ready, b_ready,
`ifdef DEMUX_FIFO_STATS_EN
        input  a_count, b_count, drop_sel_x,
`endif
        input  in_ready, a_data, a_valid, b_data, b_valid, a_level, b_level
    );

    modport slave (
        input  in_data, in_valid, sel, a_ready, b_ready,
`ifdef DEMUX_FIFO_STATS_EN
        output a_count, b_count, drop_sel_x,
`endif
        output in_ready, a_data, a_valid, b_data, b_valid, a_level, b_level
    );
endinterface

// File: rtl/demux_fifo.sv
// 1-to-2 stream steering with an independent DEPTH-entry FIFO per output channel.
// Define DEMUX_FIFO_STATS_EN to add per-channel pop counters and a sticky SEL-unknown flag.
module demux_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    demux_fifo_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic             sel_a;
    logic             sel_b;
    logic             push_en;
    logic [1:0]       chan_sel;
    logic [1:0]       chan_ready;
    logic [1:0]       chan_valid;
    logic [1:0]       full;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [WIDTH-1:0] head  [2];
    logic [LW-1:0]    level [2];

    // Case equality so an unknown SEL selects neither channel and blocks the push
    assign sel_a      = (bus.sel === 1'b0);
    assign sel_b      = (bus.sel === 1'b1);
    assign chan_sel   = {sel_b, sel_a};
    assign chan_ready = {bus.b_ready, bus.a_ready};

    // Only SEL and registered levels feed in_ready; pops this cycle never free space early
    assign bus.in_ready = (sel_a & ~full[0]) | (sel_b & ~full[1]);
    assign push_en      = bus.in_valid & bus.in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [WIDTH-1:0] mem_reg [DEPTH];
            logic [PW-1:0]    wr_ptr_reg;
            logic [PW-1:0]    rd_ptr_reg;
            logic [LW-1:0]    level_reg;

            assign full[gi]       = (level_reg == FULL_LEVEL);
            assign chan_valid[gi] = (level_reg != '0);
            assign push[gi]       = push_en & chan_sel[gi];
            assign pop[gi]        = chan_valid[gi] & chan_ready[gi];
            assign head[gi]       = mem_reg[rd_ptr_reg];
            assign level[gi]      = level_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_reg[i] <= '0;
                    end
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    level_reg  <= '0;
                end else begin
                    if (push[gi]) begin
                        mem_reg[wr_ptr_reg] <= bus.in_data;
                        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    if (push[gi] && !pop[gi]) begin
                        level_reg <= level_reg + 1'b1;
                    end else if (!push[gi] && pop[gi]) begin
                        level_reg <= level_reg - 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign bus.a_data  = head[0];
    assign bus.b_data  = head[1];
    assign bus.a_valid = chan_valid[0];
    assign bus.b_valid = chan_valid[1];
    assign bus.a_level = level[0];
    assign bus.b_level = level[1];

`ifdef DEMUX_FIFO_STATS_EN
    logic [15:0] pop_count [2];
    logic        drop_sel_x_reg;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_stats
            logic [15:0] count_reg;

            assign pop_count[gi] = count_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count_reg <= '0;
                end else if (pop[gi]) begin
                    count_reg <= count_reg + 16'd1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_sel_x_reg <= 1'b0;
        end else if (bus.in_valid && !sel_a && !sel_b) begin
            drop_sel_x_reg <= 1'b1;
        end
    end

    assign bus.a_count    = pop_count[0];
    assign bus.b_count    = pop_count[1];
    assign bus.drop_sel_x = drop_sel_x_reg;
`endif
endmodule

// File: tb/tb_demux_fifo.sv
// Self-checking bench for demux_fifo (WIDTH=8, DEPTH=2): vector table, directed corner
// sequences and a randomized run against a queue-based model of the two channels.
module tb_demux_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic             sel;
        logic             vld;
        logic [WIDTH-1:0] din;
        logic             ar;
        logic             br;
        logic             rdy;
        logic             av;
        logic [WIDTH-1:0] ad;
        logic             bv;
        logic [WIDTH-1:0] bd;
        logic [LW-1:0]    al;
        logic [LW-1:0]    bl;
    } vec_t;

    vec_t tbl [11];

    logic [WIDTH-1:0] qa [$];
    logic [WIDTH-1:0] qb [$];
    int               pops_a;

    task automatic drive(input logic s, input logic v, input logic [WIDTH-1:0] d,
                         input logic ar, input logic br);
        bus.sel      = s;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.a_ready  = ar;
        bus.b_ready  = br;
    endtask

    initial begin
        logic exp_rdy, do_push, do_pa, do_pb;

        //        sel   vld   din     ar    br  | rdy   av    ad      bv    bd      al    bl
        tbl[0]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 2'd1, 2'd0};
        tbl[1]  = '{1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h22, 2'd0, 2'd1};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 2'd0};
        tbl[3]  = '{1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b0, 8'h00, 2'd1, 2'd0};
        tbl[4]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b0, 8'h00, 2'd2, 2'd0};
        tbl[5]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b0, 8'h00, 2'd2, 2'd0};
        tbl[6]  = '{1'b1, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b1, 8'hB0, 2'd2, 2'd1};
        tbl[7]  = '{1'b0, 1'b1, 8'hA2, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 8'hB0, 2'd1, 2'd1};
        tbl[8]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 8'h00, 2'd2, 2'd0};
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 1'b0, 8'h00, 2'd1, 2'd0};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 2'd0};

        // Reset state
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        chk("rst_a_valid",  bus.a_valid,  0);
        chk("rst_b_valid",  bus.b_valid,  0);
        chk("rst_a_level",  bus.a_level,  0);
        chk("rst_b_level",  bus.b_level,  0);
        chk("rst_a_data",   bus.a_data,   0);
        chk("rst_b_data",   bus.b_data,   0);
        chk("rst_in_ready", bus.in_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed vector table: pushes, full stall, pop-while-full, cross-channel independence
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(tbl[i].sel, tbl[i].vld, tbl[i].din, tbl[i].ar, tbl[i].br);
            #1;
            chk($sformatf("tbl%0d_in_ready", i), bus.in_ready, tbl[i].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_a_valid", i), bus.a_valid, tbl[i].av);
            chk($sformatf("tbl%0d_b_valid", i), bus.b_valid, tbl[i].bv);
            chk($sformatf("tbl%0d_a_level", i), bus.a_level, tbl[i].al);
            chk($sformatf("tbl%0d_b_level", i), bus.b_level, tbl[i].bl);
            if (tbl[i].av) chk($sformatf("tbl%0d_a_data", i), bus.a_data, tbl[i].ad);
            if (tbl[i].bv) chk($sformatf("tbl%0d_b_data", i), bus.b_data, tbl[i].bd);
            $display("vec %0d sel=%0d vld=%0d din=%02h ar=%0d br=%0d -> a=%0d/%02h/%0d b=%0d/%02h/%0d",
                     i, tbl[i].sel, tbl[i].vld, tbl[i].din, tbl[i].ar, tbl[i].br,
                     bus.a_valid, bus.a_data, bus.a_level, bus.b_valid, bus.b_data, bus.b_level);
        end

        // Alternating push/pop on B walks the pointers through several wraps
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
            #1;
            chk($sformatf("wrap%0d_in_ready", i), bus.in_ready, 1);
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d_b_level_push", i), bus.b_level, 1);
            chk($sformatf("wrap%0d_b_data", i), bus.b_data, 8'(8'h50 + i));
            @(negedge clk);
            drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d_b_level_pop", i), bus.b_level, 0);
            chk($sformatf("wrap%0d_b_valid_pop", i), bus.b_valid, 0);
            $display("wrap %0d pushed/popped %02h on B", i, 8'(8'h50 + i));
        end

        // Asynchronous reset in the middle of a cycle with traffic queued
        @(negedge clk);
        drive(1'b0, 1'b1, 8'hC0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 8'hC1, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        chk("arst_a_valid",  bus.a_valid,  0);
        chk("arst_b_valid",  bus.b_valid,  0);
        chk("arst_a_level",  bus.a_level,  0);
        chk("arst_b_level",  bus.b_level,  0);
        chk("arst_in_ready", bus.in_ready, 1);
        $display("async reset asserted mid-cycle with traffic queued");
        @(negedge clk);
        rst = 1'b0;
        qa.delete();
        qb.delete();
        pops_a = 0;

        // Randomized traffic against the queue model
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 8'($urandom),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
            #1;
            exp_rdy = bus.sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
            chk("rnd_in_ready", bus.in_ready, exp_rdy);
            chk("rnd_a_valid",  bus.a_valid,  qa.size() != 0);
            chk("rnd_b_valid",  bus.b_valid,  qb.size() != 0);
            chk("rnd_a_level",  bus.a_level,  qa.size());
            chk("rnd_b_level",  bus.b_level,  qb.size());
            if (qa.size() != 0) chk("rnd_a_data", bus.a_data, qa[0]);
            if (qb.size() != 0) chk("rnd_b_data", bus.b_data, qb[0]);
            do_push = bus.in_valid && exp_rdy;
            do_pa   = (qa.size() != 0) && bus.a_ready;
            do_pb   = (qb.size() != 0) && bus.b_ready;
            @(posedge clk);
            if (do_pa) begin
                void'(qa.pop_front());
                pops_a++;
            end
            if (do_pb) void'(qb.pop_front());
            if (do_push) begin
                if (bus.sel) qb.push_back(bus.in_data);
                else         qa.push_back(bus.in_data);
            end
            if (do_push || do_pa || do_pb)
                $display("rnd %0d push=%0d sel=%0d data=%02h popA=%0d popB=%0d",
                         n, do_push, bus.sel, bus.in_data, do_pa, do_pb);
        end

`ifdef DEMUX_FIFO_STATS_EN
        #1;
        chk("a_count", bus.a_count, 32'(pops_a[15:0]));
`endif

        // Unknown SEL with a valid word must neither push nor raise in_ready
        @(negedge clk);
        drive(1'bx, 1'b1, 8'h77, 1'b0, 1'b0);
        #1;
        if ($isunknown(bus.sel)) begin
            chk("selx_in_ready", bus.in_ready, 0);
            @(posedge clk);
            #1;
            chk("selx_a_level", bus.a_level, qa.size());
            chk("selx_b_level", bus.b_level, qb.size());
`ifdef DEMUX_FIFO_STATS_EN
            chk("selx_drop_flag", bus.drop_sel_x, 1);
`endif
            $display("sel_x: valid word with unknown SEL dropped");
        end else begin
            $display("sel_x: simulator is two-state, unknown SEL not representable; step skipped");
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
